pulse_period_checker: RTL and testbench
=======================================

# pulse_period_checker

Receive-side monitor for the periodic single-cycle pulse stream produced by the team's pulse-every-N-cycles generators. Measures the interval between consecutive pulses and flags early and missing pulses. Asserts a lock indication after a run of correctly spaced pulses. Sits downstream of the pulse generator, or across a link carrying its output, as a liveness and period checker.

## Interface
- EXP_PERIOD, 10, expected pulse spacing in clock cycles; legal range 2 to 2^CNT_W−1.
- CNT_W, 8, width of the interval counter and of period_out.
- LOCK_CNT, 3, consecutive good intervals required to assert locked; minimum 1.
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  checker active when high.
- pulse_in  input  1  monitored pulse; nominally high for 1 cycle every EXP_PERIOD cycles.
- period_out  output  CNT_W  last measured interval in cycles.
- period_valid  output  1  1-cycle strobe; period_out updated.
- err_early  output  1  1-cycle strobe; pulse arrived with interval < EXP_PERIOD.
- err_missing  output  1  1-cycle strobe; no pulse by EXP_PERIOD cycles.
- locked  output  1  level; stream judged periodic.
- err_count  output  8  saturating count of err_early + err_missing events.

## Operation
- States: IDLE, ACQUIRE, TRACK, LOCKED. Internal: cnt[CNT_W-1:0], good[ceil(log2(LOCK_CNT+1))-1:0].
- IDLE: entered on reset or whenever enable=0, regardless of state. cnt=0, good=0, locked=0. Strobes held 0. enable=1 → ACQUIRE.
- ACQUIRE: waiting for the first pulse. No timeout, no strobes. On pulse_in=1: cnt<=1 → TRACK. No period_valid, because there is no prior reference.
- TRACK / LOCKED, counting: in a cycle with no pulse, cnt<=cnt+1. The interval is the value of cnt in the cycle pulse_in=1. Pulses at cycles t and t+EXP_PERIOD give interval EXP_PERIOD.
- Pulse with cnt==EXP_PERIOD (good):
  - period_valid=1 and period_out=cnt; cnt<=1.
  - If good<LOCK_CNT, good increments. When it reaches LOCK_CNT: locked=1 and the state goes to LOCKED.
- Pulse with cnt<EXP_PERIOD (early):
  - period_valid=1 and period_out=cnt; err_early=1.
  - good<=0, locked<=0, cnt<=1, state → TRACK. The pulse restarts measurement.
- No pulse and cnt==EXP_PERIOD (missing):
  - err_missing=1, good<=0, locked<=0, cnt<=0, state → ACQUIRE.
  - cnt never exceeds EXP_PERIOD.
- Simultaneous events:
  - enable=0 with pulse_in=1: enable wins; no strobes.
  - Pulse exactly at cnt==EXP_PERIOD: good interval, never missing.
- err_count increments by 1 per err_early or err_missing strobe and saturates at 255. It is cleared only by rst; enable=0 does not clear it.

## Timing
- All outputs are registered. Every strobe appears in the cycle after the triggering edge sample, i.e. 1-cycle latency from pulse_in.
- locked rises in the same cycle as the period_valid that completes the LOCK_CNT-th good interval. It falls in the same cycle as err_early or err_missing.
- Reset values: period_out=0, period_valid=0, err_early=0, err_missing=0, locked=0, err_count=0, state=IDLE.
- Reset mid-operation takes effect at the next edge and drops locked immediately. The first pulse after release is handled as an ACQUIRE pulse.
- pulse_in held high for multiple cycles: each high cycle counts as a pulse. The second cycle is measured as interval 1, so it is early.
- Throughput: one pulse can be accepted per cycle; no back-pressure.

## Configuration
- PULSE_CHK_ERRCNT_EN defined: the err_count saturating counter is built as described.
- Not defined: err_count is tied to 8'd0 and no counter logic is synthesized. All other behaviour is identical.

## Test plan
- Lock: enable=1, 5 pulses spaced 10 cycles. Required: no period_valid on pulse 1; period_valid with period_out=10 on pulses 2–5; locked=1 after pulse 4; no errors.
- Early: after lock, next pulse 7 cycles after the previous one. Required: period_valid with period_out=7, err_early=1, locked=0, err_count=1. The next 3 pulses at spacing 10 relock.
- Missing: after lock, stop pulses. Required: err_missing=1 exactly 10 cycles after the last pulse, locked=0, one strobe only (no repeats while idle in ACQUIRE).
- Enable/reset: drop enable while locked, with a simultaneous pulse. Required: locked=0, no strobes, err_count unchanged. Assert rst: all outputs 0 next cycle.
- Stuck-high: pulse_in high for 3 cycles. Required: two err_early strobes, period_out=1 each time.
- Saturation (PULSE_CHK_ERRCNT_EN defined): 300 early events. Required: err_count=255 and stays there. With the macro undefined: err_count=0 throughout.

Source files
------------

// File: rtl/pulse_period_checker.sv
// pulse_period_checker
//   Receive-side monitor for a periodic single-cycle pulse stream. Measures
//   the spacing between consecutive pulses, flags early and missing pulses,
//   and asserts a lock level after LOCK_CNT consecutive correctly spaced
//   intervals.
//
// Parameters
//   EXP_PERIOD  expected pulse spacing in cycles (2 .. 2^CNT_W-1)
//   CNT_W       width of the interval counter and period_out
//   LOCK_CNT    consecutive good intervals needed to lock (>= 1)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   enable       checker active when high; low forces IDLE
//   pulse_in     monitored pulse
//   period_out   last measured interval (cycles)
//   period_valid 1-cycle strobe, period_out updated
//   err_early    1-cycle strobe, interval shorter than EXP_PERIOD
//   err_missing  1-cycle strobe, no pulse within EXP_PERIOD cycles
//   locked       level, stream judged periodic
//   err_count    saturating count of early + missing events
//
// Build option
//   PULSE_CHK_ERRCNT_EN  when defined, err_count is a saturating 8-bit
//                        counter; otherwise err_count is constant zero.
//
// All outputs are registered: every strobe is visible in the cycle after
// the clock edge that sampled the triggering pulse_in value.

module pulse_period_checker #(
  parameter int EXP_PERIOD = 10,
  parameter int CNT_W      = 8,
  parameter int LOCK_CNT   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             err_early,
  output logic             err_missing,
  output logic             locked,
  output logic [7:0]       err_count
);

  localparam int GOOD_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0]  EXP_CNT   = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [GOOD_W-1:0] LOCK_LAST = GOOD_W'(LOCK_CNT - 1);
  localparam logic [GOOD_W-1:0] LOCK_FULL = GOOD_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_TRACK   = 2'd2,
    S_LOCKED  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic              locked_q, locked_d;
  logic [CNT_W-1:0]  period_out_q, period_out_d;
  logic              period_valid_q, period_valid_d;
  logic              err_early_q, err_early_d;
  logic              err_missing_q, err_missing_d;

  // Next-state and next-output computation.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    good_d         = good_q;
    locked_d       = locked_q;
    period_out_d   = period_out_q;
    period_valid_d = 1'b0;
    err_early_d    = 1'b0;
    err_missing_d  = 1'b0;

    if (!enable) begin
      // Disable overrides everything, including a coincident pulse.
      state_d  = S_IDLE;
      cnt_d    = '0;
      good_d   = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d  = S_ACQUIRE;
          cnt_d    = '0;
          good_d   = '0;
          locked_d = 1'b0;
        end

        S_ACQUIRE: begin
          // First pulse only establishes the reference point.
          if (pulse_in) begin
            cnt_d   = CNT_ONE;
            state_d = S_TRACK;
          end
        end

        S_TRACK, S_LOCKED: begin
          if (pulse_in) begin
            period_valid_d = 1'b1;
            period_out_d   = cnt_q;
            cnt_d          = CNT_ONE;
            if (cnt_q == EXP_CNT) begin
              // A pulse exactly at the deadline is good, never missing.
              if (good_q >= LOCK_LAST) begin
                good_d   = LOCK_FULL;
                locked_d = 1'b1;
                state_d  = S_LOCKED;
              end else begin
                good_d = good_q + 1'b1;
              end
            end else begin
              err_early_d = 1'b1;
              good_d      = '0;
              locked_d    = 1'b0;
              state_d     = S_TRACK;
            end
          end else if (cnt_q == EXP_CNT) begin
            // Deadline passed without a pulse: fall back to acquisition so
            // the missing strobe fires once, not every period.
            err_missing_d = 1'b1;
            good_d        = '0;
            locked_d      = 1'b0;
            cnt_d         = '0;
            state_d       = S_ACQUIRE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        default: begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          good_d   = '0;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      good_q         <= '0;
      locked_q       <= 1'b0;
      period_out_q   <= '0;
      period_valid_q <= 1'b0;
      err_early_q    <= 1'b0;
      err_missing_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      good_q         <= good_d;
      locked_q       <= locked_d;
      period_out_q   <= period_out_d;
      period_valid_q <= period_valid_d;
      err_early_q    <= err_early_d;
      err_missing_q  <= err_missing_d;
    end
  end

  assign period_out   = period_out_q;
  assign period_valid = period_valid_q;
  assign err_early    = err_early_q;
  assign err_missing  = err_missing_q;
  assign locked       = locked_q;

`ifdef PULSE_CHK_ERRCNT_EN
  // Counts error strobes; survives enable=0, cleared only by rst.
  logic [7:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if ((err_early_d || err_missing_d) && (err_count_q != 8'hFF))
      err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_count_q <= 8'd0;
    else     err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_pulse_period_checker.sv
// Directed self-checking bench for pulse_period_checker (EXP_PERIOD=10,
// CNT_W=8, LOCK_CNT=3). Inputs change 1 ns after each rising edge; outputs
// are sampled at that same point, so each check sees the result of the
// edge that sampled the previous input values.
module tb_pulse_period_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       pulse_in;
  logic [7:0] period_out;
  logic       period_valid;
  logic       err_early;
  logic       err_missing;
  logic       locked;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

`ifdef PULSE_CHK_ERRCNT_EN
  localparam bit EC_ON = 1'b1;
`else
  localparam bit EC_ON = 1'b0;
`endif

  pulse_period_checker #(.EXP_PERIOD(10), .CNT_W(8), .LOCK_CNT(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .pulse_in    (pulse_in),
    .period_out  (period_out),
    .period_valid(period_valid),
    .err_early   (err_early),
    .err_missing (err_missing),
    .locked      (locked),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ec(input int n);
    if (!EC_ON) return 8'd0;
    return (n > 255) ? 8'd255 : 8'(n);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic p);
    pulse_in = p;
    @(posedge clk);
    #1;
  endtask

  // Quiet cycles; no strobe may fire during any of them.
  task automatic quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step(1'b0);
      chk(tag, {period_valid, err_early, err_missing}, 3'b000);
    end
  endtask

  // Good pulse: interval 10, no errors, given lock level.
  task automatic good_pulse(input string tag, input logic exp_lock, input int exp_ec);
    quiet(9, {tag, "_gap"});
    step(1'b1);
    chk({tag, "_pv"},   period_valid, 1'b1);
    chk({tag, "_per"},  period_out, 32'd10);
    chk({tag, "_err"},  {err_early, err_missing}, 2'b00);
    chk({tag, "_lock"}, locked, exp_lock);
    chk({tag, "_ec"},   err_count, ec(exp_ec));
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; pulse_in = 1'b0;
    step(1'b0);
    step(1'b0);
    chk("reset_outs", {period_out, period_valid, err_early, err_missing, locked, err_count},
        '0);
    rst = 1'b0;

    // Lock: IDLE -> ACQUIRE, then five pulses spaced 10.
    enable = 1'b1;
    step(1'b0);
    step(1'b1);
    chk("lock_p1_nopv", {period_valid, err_early, err_missing, locked}, 4'b0000);
    good_pulse("lock_p2", 1'b0, 0);
    good_pulse("lock_p3", 1'b0, 0);
    good_pulse("lock_p4", 1'b1, 0);
    good_pulse("lock_p5", 1'b1, 0);

    // Early: 7 cycles after the previous pulse.
    quiet(6, "early_gap");
    step(1'b1);
    chk("early_pv",   period_valid, 1'b1);
    chk("early_per",  period_out, 32'd7);
    chk("early_ee",   err_early, 1'b1);
    chk("early_em",   err_missing, 1'b0);
    chk("early_lock", locked, 1'b0);
    chk("early_ec",   err_count, ec(1));
    good_pulse("relock1", 1'b0, 1);
    good_pulse("relock2", 1'b0, 1);
    good_pulse("relock3", 1'b1, 1);

    // Missing: stop pulses; strobe exactly 10 cycles after the last pulse.
    quiet(9, "miss_wait");
    chk("miss_still_locked", locked, 1'b1);
    step(1'b0);
    chk("miss_em",   err_missing, 1'b1);
    chk("miss_pv",   {period_valid, err_early}, 2'b00);
    chk("miss_lock", locked, 1'b0);
    chk("miss_ec",   err_count, ec(2));
    quiet(25, "miss_no_repeat");

    // Reacquire and lock, then drop enable with a coincident pulse.
    step(1'b1);
    chk("reacq_nopv", period_valid, 1'b0);
    good_pulse("en_g1", 1'b0, 2);
    good_pulse("en_g2", 1'b0, 2);
    good_pulse("en_g3", 1'b1, 2);
    quiet(9, "en_gap");
    enable = 1'b0;
    step(1'b1);
    chk("en_off_lock", locked, 1'b0);
    chk("en_off_strb", {period_valid, err_early, err_missing}, 3'b000);
    chk("en_off_ec",   err_count, ec(2));
    step(1'b1);
    chk("en_off_strb2", {period_valid, err_early, err_missing}, 3'b000);
    enable = 1'b1;
    step(1'b0);
    chk("en_on_ec", err_count, ec(2));

    // Stuck-high for 3 cycles from ACQUIRE: acquire, then two interval-1 earlies.
    step(1'b1);
    chk("stuck_c1", {period_valid, err_early}, 2'b00);
    step(1'b1);
    chk("stuck_c2_ee",  err_early, 1'b1);
    chk("stuck_c2_per", period_out, 32'd1);
    chk("stuck_c2_ec",  err_count, ec(3));
    step(1'b1);
    chk("stuck_c3_ee",  err_early, 1'b1);
    chk("stuck_c3_per", period_out, 32'd1);
    chk("stuck_c3_ec",  err_count, ec(4));
    step(1'b0);
    chk("stuck_after", {period_valid, err_early, err_missing}, 3'b000);

    // Mid-operation reset clears everything including err_count.
    rst = 1'b1;
    step(1'b1);
    chk("rst_mid", {period_out, period_valid, err_early, err_missing, locked, err_count}, '0);
    rst = 1'b0;
    step(1'b0);
    step(1'b1);
    chk("rst_acq_nopv", {period_valid, err_early, err_missing}, 3'b000);

    // Saturation: from TRACK (cnt=1), 300 consecutive high cycles are 300 earlies.
    for (int i = 0; i < 300; i++) begin
      step(1'b1);
      if (i == 9)  chk("sat_10",  err_count, ec(10));
      if (i == 254) chk("sat_255", err_count, ec(255));
    end
    chk("sat_end", err_count, ec(300));
    chk("sat_ee",  err_early, 1'b1);
    step(1'b1);
    chk("sat_hold", err_count, ec(301));
    step(1'b0);
    chk("sat_final", err_count, ec(301));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
